fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_if.sv | 27 ++
 rtl/fetch_stage.sv | 133 +++++++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// Fetch stage bus bundle: instruction-memory port, redirect input and decode-side FIFO head.
// Latency: none, wires only.
// Backpressure: decode stalls the head entry through i_inst_ready; memory answers with i_imem_ack pulses.
interface fetch_stage_if;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack;
  logic [31:0] i_imem_rdata;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic        o_inst_valid;
  logic        i_inst_ready;

  // Fetch stage side.
  modport master (
    output o_imem_req, o_imem_addr, o_inst, o_inst_pc, o_inst_valid,
    input  i_imem_ack, i_imem_rdata, i_redirect, i_redirect_pc, i_inst_ready
  );

  // Memory / decode / branch-unit side.
  modport slave (
    input  o_imem_req, o_imem_addr, o_inst, o_inst_pc, o_inst_valid,
    output i_imem_ack, i_imem_rdata, i_redirect, i_redirect_pc, i_inst_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding memory request feeding a 2-entry {pc, inst} FIFO toward decode.
// Latency: request at N, ack at N+1, entry valid at N+2; redirect restarts fetch the following cycle.
// Backpressure: a full FIFO (count + outstanding = 2) blocks issue; redirect flushes and drops the in-flight response.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic           i_clk,
  input logic           i_rst,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pending_pc_q, pending_pc_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] head_pc_q, head_pc_d;
  logic [31:0] head_inst_q, head_inst_d;
  logic [31:0] tail_pc_q, tail_pc_d;
  logic [31:0] tail_inst_q, tail_inst_d;

  logic        issue;
  logic        push;
  logic        pop;
  logic [1:0]  base;

  // Issue only from FETCH (nothing outstanding) while the FIFO still has room
  // for the response; a redirect or reset in the same cycle suppresses it.
  assign issue = !i_rst && !bus.i_redirect && (state_q == FETCH) && (count_q < 2'd2);
  // Only a response to a live request is kept; a redirect discards it.
  assign push  = (state_q == WAIT) && bus.i_imem_ack && !bus.i_redirect;
  assign pop   = (count_q != 2'd0) && bus.i_inst_ready && !bus.i_redirect;

  // FIFO next state: pop shifts tail into head, push lands at the first free slot.
  always_comb begin
    head_pc_d   = head_pc_q;
    head_inst_d = head_inst_q;
    tail_pc_d   = tail_pc_q;
    tail_inst_d = tail_inst_q;
    count_d     = count_q;
    base        = count_q;
    if (bus.i_redirect) begin
      count_d = 2'd0;
    end else begin
      if (pop) begin
        head_pc_d   = tail_pc_q;
        head_inst_d = tail_inst_q;
        base        = count_q - 2'd1;
      end
      if (push) begin
        if (base == 2'd0) begin
          head_pc_d   = pending_pc_q;
          head_inst_d = bus.i_imem_rdata;
        end else begin
          tail_pc_d   = pending_pc_q;
          tail_inst_d = bus.i_imem_rdata;
        end
      end
      count_d = base + {1'b0, push};
    end
  end

  // Request FSM and fetch address: at most one request in flight; DROP waits
  // out a response that a redirect has made stale.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    case (state_q)
      FETCH: begin
        if (issue) begin
          state_d      = WAIT;
          pending_pc_d = fetch_pc_q;
          fetch_pc_d   = fetch_pc_q + 32'd4;
        end
      end
      WAIT: begin
        if (bus.i_redirect) begin
          state_d = bus.i_imem_ack ? FETCH : DROP;
        end else if (bus.i_imem_ack) begin
          state_d = FETCH;
        end
      end
      DROP: begin
        // The stale response is consumed here whether or not another redirect arrives.
        if (bus.i_imem_ack) begin
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
    if (bus.i_redirect) begin
      fetch_pc_d = bus.i_redirect_pc & ~32'd3;
    end
  end

  // State registers with synchronous reset; reset overrides redirect.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= FETCH;
      fetch_pc_q   <= RESET_PC;
      pending_pc_q <= 32'd0;
      count_q      <= 2'd0;
      head_pc_q    <= 32'd0;
      head_inst_q  <= 32'd0;
      tail_pc_q    <= 32'd0;
      tail_inst_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
      count_q      <= count_d;
      head_pc_q    <= head_pc_d;
      head_inst_q  <= head_inst_d;
      tail_pc_q    <= tail_pc_d;
      tail_inst_q  <= tail_inst_d;
    end
  end

  // The request is combinational so that redirect and reset can squash it in
  // the same cycle; everything toward decode comes straight from registers.
  assign bus.o_imem_req   = issue;
  assign bus.o_imem_addr  = fetch_pc_q;
  assign bus.o_inst       = head_inst_q;
  assign bus.o_inst_pc    = head_pc_q;
  assign bus.o_inst_valid = (count_q != 2'd0);

endmodule
